// File: rtl/rv_ctrl_pkg.sv
// Shared state, opcode and control-word definitions for the multi-cycle RV32 sequencer.
// Combinational types only; no latency or flow control lives here.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    R_WB     = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    LOAD_WB  = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  // States that hold the shared memory port and wait on mem_ready.
  function automatic logic is_mem_wait(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore control-word decode of the sequencer state (plus zero in BRANCH, mem_ready in FETCH).
// Purely combinational; strobes are held low while reset is asserted.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic   reset,
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  ctrl_t raw;

  always_comb begin
    raw = '0;
    case (state)
      FETCH: begin
        raw.mem_read = 1'b1;
        if (mem_ready) begin
          raw.ir_write  = 1'b1;
          raw.pc_write  = 1'b1;
          raw.alu_src_b = SRCB_FOUR;
          raw.alu_op    = ALU_ADD;
        end
      end
      DECODE: begin
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_RS2;
        raw.alu_op    = ALU_FUNCT;
      end
      R_WB: raw.reg_write = 1'b1;
      MEM_ADDR: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_IMM;
        raw.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        raw.mem_read = 1'b1;
        raw.iord     = 1'b1;
      end
      LOAD_WB: begin
        raw.reg_write  = 1'b1;
        raw.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        raw.mem_write = 1'b1;
        raw.iord      = 1'b1;
      end
      BRANCH: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = SRCB_RS2;
        raw.alu_op    = ALU_SUB;
        raw.pc_src    = 1'b1;
        raw.pc_write  = zero;
      end
      TRAP:    raw.halted = 1'b1;
      default: raw = '0;
    endcase
  end

  // halted reflects the state itself; only the strobes are suppressed during reset.
  always_comb begin
    ctrl = raw;
    if (reset) begin
      ctrl        = '0;
      ctrl.halted = raw.halted;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: state register, memory wait/timeout counter, instret/cycle counters.
// R 4 / load 5 / store 4 / branch 3 cycles at zero wait; stalls on mem_ready, traps after MEM_TIMEOUT.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       stalled, expired, retire;
  ctrl_t      ctrl;

  assign stalled = is_mem_wait(state) && !mem_ready;
  assign expired = stalled && (wait_cnt == TMO);

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      FETCH: if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:              state_nxt = EXEC_R;
          OP_LOAD, OP_STORE: state_nxt = MEM_ADDR;
          OP_BRANCH:         state_nxt = BRANCH;
          default:           state_nxt = TRAP;
        endcase
      end
      EXEC_R: state_nxt = R_WB;
      R_WB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      MEM_ADDR: begin
        if (opcode == OP_LOAD)       state_nxt = MEM_RD;
        else if (opcode == OP_STORE) state_nxt = MEM_WR;
        else                         state_nxt = TRAP;
      end
      MEM_RD: if (mem_ready) state_nxt = LOAD_WB;
      LOAD_WB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      BRANCH: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = TRAP;
    endcase
    if (expired) state_nxt = TRAP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      instret   <= '0;
      cycles    <= '0;
      bus_error <= 1'b0;
    end else begin
      state  <= state_nxt;
      cycles <= cycles + CNT_W'(1);
      if (retire) instret <= instret + CNT_W'(1);
      if (expired) bus_error <= 1'b1;
      // Any exit from a wait state clears the counter, so every entry starts from zero.
      if (stalled && !expired) wait_cnt <= wait_cnt + 8'd1;
      else                     wait_cnt <= '0;
    end
  end

  ctrl_decode u_decode (
    .reset     (reset),
    .state     (state),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign iord       = ctrl.iord;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign halted     = ctrl.halted;

endmodule
